// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake plus SRAM array-side signals for sram_access_ctrl.
// The slave modport is the controller; the master modport is the requester and array model.
interface sram_access_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_we;
   logic [DATA_W-1:0] rsp_rdata;
   logic [2:0]        addr;
   logic              wl_valid;
   logic              precharge;
   logic              write_en;
   logic [DATA_W-1:0] wdata;
   logic              sense_en;
   logic [DATA_W-1:0] sa_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, sa_data,
      input  req_ready, rsp_valid, rsp_we, rsp_rdata,
      input  addr, wl_valid, precharge, write_en, wdata, sense_en
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sa_data,
      output req_ready, rsp_valid, rsp_we, rsp_rdata,
      output addr, wl_valid, precharge, write_en, wdata, sense_en
   );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences one SRAM access at a time: precharge, wordline, optional sense, then response.
// Every array-side strobe is a register, so the array never sees glitches from inputs.
module sram_access_ctrl #(
   parameter int DATA_W  = 8,
   parameter int PRE_CYC = 2,
   parameter int WL_CYC  = 2
) (
   input logic               clk,
   input logic               rst,
   sram_access_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PRECHG, ACCESS, SENSE, RESP} state_t;

   localparam logic [3:0]        PRE_LOAD  = 4'(PRE_CYC - 1);
   localparam logic [3:0]        WL_LOAD   = 4'(WL_CYC - 1);
   localparam logic [DATA_W-1:0] DATA_ZERO = '0;

   state_t     state;
   logic [3:0] phase_cnt;

   // Outputs are set on the edge that enters each state, so they are valid for the whole state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         phase_cnt     <= 4'd0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_we    <= 1'b0;
         bus.rsp_rdata <= DATA_ZERO;
         bus.addr      <= 3'd0;
         bus.wdata     <= DATA_ZERO;
         bus.wl_valid  <= 1'b0;
         bus.precharge <= 1'b0;
         bus.write_en  <= 1'b0;
         bus.sense_en  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  bus.addr      <= bus.req_addr;
                  bus.rsp_we    <= bus.req_we;
                  bus.wdata     <= bus.req_wdata;
                  bus.req_ready <= 1'b0;
                  bus.precharge <= 1'b1;
                  phase_cnt     <= PRE_LOAD;
                  state         <= PRECHG;
               end
            end
            PRECHG: begin
               if (phase_cnt == 4'd0) begin
                  bus.precharge <= 1'b0;
                  bus.wl_valid  <= 1'b1;
                  bus.write_en  <= bus.rsp_we;
                  phase_cnt     <= WL_LOAD;
                  state         <= ACCESS;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            ACCESS: begin
               if (phase_cnt == 4'd0) begin
                  bus.write_en <= 1'b0;
                  phase_cnt    <= 4'd0;
                  // Reads keep the wordline up through the sense cycle; writes are done.
                  if (bus.rsp_we) begin
                     bus.wl_valid  <= 1'b0;
                     bus.rsp_valid <= 1'b1;
                     state         <= RESP;
                  end else begin
                     bus.sense_en <= 1'b1;
                     state        <= SENSE;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            SENSE: begin
               bus.wl_valid  <= 1'b0;
               bus.sense_en  <= 1'b0;
               bus.rsp_rdata <= bus.sa_data;
               bus.rsp_valid <= 1'b1;
               phase_cnt     <= 4'd0;
               state         <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  phase_cnt     <= 4'd0;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.req_ready <= 1'b1;
               bus.rsp_valid <= 1'b0;
               bus.wl_valid  <= 1'b0;
               bus.precharge <= 1'b0;
               bus.write_en  <= 1'b0;
               bus.sense_en  <= 1'b0;
               phase_cnt     <= 4'd0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: a default-timing instance and a PRE_CYC=1/WL_CYC=15 instance,
// driven from shared stimulus with a select, checked against hand-computed cycle numbers.
module tb_sram_access_ctrl;
   typedef struct {
      bit         sel;
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] sa;
      int         bp;
      int         expRspEdge;
      int         expPreFirst;
      int         expPreLast;
      int         expWlFirst;
      int         expWlLast;
      int         expWeFirst;
      int         expWeCount;
      int         expSense;
      logic [7:0] expRdata;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   bit         sel = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_we = 1'b0;
   logic [2:0] req_addr = 3'd0;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_ready = 1'b0;
   logic [7:0] sa_data = 8'h00;
   int         edgeCnt = 0;
   int         checks = 0;
   int         errors = 0;

   logic       m_req_ready, m_rsp_valid, m_rsp_we;
   logic [7:0] m_rsp_rdata, m_wdata;
   logic [2:0] m_addr;
   logic       m_wl_valid, m_precharge, m_write_en, m_sense_en;

   int obsAcceptReady, obsRspEdge, obsPreFirst, obsPreLast, obsPreCount;
   int obsWlFirst, obsWlLast, obsWlCount, obsWeFirst, obsWeCount;
   int obsSenseFirst, obsSenseCount, obsRegBad, obsReadyBad, obsHoldBad, obsIdleOk;
   logic [7:0] obsRdata;
   logic       obsRspWe;

   vec_t vecs[8];
   vec_t rstVec;
   int   a0, a1, hs, n;

   sram_access_ctrl_if #(.DATA_W(8)) bus0 ();
   sram_access_ctrl_if #(.DATA_W(8)) bus1 ();

   assign bus0.req_valid = req_valid & ~sel;
   assign bus1.req_valid = req_valid & sel;
   assign bus0.req_we    = req_we;
   assign bus1.req_we    = req_we;
   assign bus0.req_addr  = req_addr;
   assign bus1.req_addr  = req_addr;
   assign bus0.req_wdata = req_wdata;
   assign bus1.req_wdata = req_wdata;
   assign bus0.rsp_ready = rsp_ready & ~sel;
   assign bus1.rsp_ready = rsp_ready & sel;
   assign bus0.sa_data   = sa_data;
   assign bus1.sa_data   = sa_data;

   assign m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
   assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
   assign m_rsp_we    = sel ? bus1.rsp_we    : bus0.rsp_we;
   assign m_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
   assign m_addr      = sel ? bus1.addr      : bus0.addr;
   assign m_wdata     = sel ? bus1.wdata     : bus0.wdata;
   assign m_wl_valid  = sel ? bus1.wl_valid  : bus0.wl_valid;
   assign m_precharge = sel ? bus1.precharge : bus0.precharge;
   assign m_write_en  = sel ? bus1.write_en  : bus0.write_en;
   assign m_sense_en  = sel ? bus1.sense_en  : bus0.sense_en;

   sram_access_ctrl #(.DATA_W(8), .PRE_CYC(2), .WL_CYC(2)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   sram_access_ctrl #(.DATA_W(8), .PRE_CYC(1), .WL_CYC(15)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // Array strobes that must never overlap, watched on both instances every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((bus0.precharge && bus0.wl_valid) || (bus0.write_en && bus0.sense_en) ||
             (bus1.precharge && bus1.wl_valid) || (bus1.write_en && bus1.sense_en)) begin
            errors++;
            $display("[TB] FAIL exclusivity at edge %0d: pre/wl/we/se dut0=%b%b%b%b dut1=%b%b%b%b, required no overlap",
                     edgeCnt, bus0.precharge, bus0.wl_valid, bus0.write_en, bus0.sense_en,
                     bus1.precharge, bus1.wl_valid, bus1.write_en, bus1.sense_en);
         end
      end
   end

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Runs one transaction from a negedge and records when each strobe was seen.
   task automatic applyStimulus(input vec_t v);
      int  cyc;
      bit  done;
      sel = v.sel;
      #1;
      obsAcceptReady = int'(m_req_ready);
      obsRspEdge = -1; obsPreFirst = -1; obsPreLast = -1; obsPreCount = 0;
      obsWlFirst = -1; obsWlLast = -1; obsWlCount = 0; obsWeFirst = -1; obsWeCount = 0;
      obsSenseFirst = -1; obsSenseCount = 0; obsRegBad = 0; obsReadyBad = 0;
      obsHoldBad = 0; obsIdleOk = 0;
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      sa_data = v.sa; rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wdata;
      cyc = 1;
      done = 1'b0;
      while (!done && cyc < 64) begin
         @(negedge clk);
         if (m_rsp_valid) begin
            obsRspEdge = cyc - 1;
            done = 1'b1;
         end else begin
            if (m_precharge) begin
               if (obsPreFirst < 0) obsPreFirst = cyc;
               obsPreLast = cyc; obsPreCount++;
            end
            if (m_wl_valid) begin
               if (obsWlFirst < 0) obsWlFirst = cyc;
               obsWlLast = cyc; obsWlCount++;
            end
            if (m_write_en) begin
               if (obsWeFirst < 0) obsWeFirst = cyc;
               obsWeCount++;
            end
            if (m_sense_en) begin
               if (obsSenseFirst < 0) obsSenseFirst = cyc;
               obsSenseCount++;
            end
            if (m_req_ready) obsReadyBad++;
         end
         if (m_addr !== v.addr || m_wdata !== v.wdata || m_rsp_we !== v.we) obsRegBad++;
         cyc++;
      end
      obsRdata = m_rsp_rdata;
      obsRspWe = m_rsp_we;
      if (done) begin
         for (int k = 0; k <= v.bp; k++) begin
            if (k > 0) @(negedge clk);
            if (!m_rsp_valid || m_rsp_rdata !== obsRdata || m_rsp_we !== obsRspWe || m_req_ready ||
                m_precharge || m_wl_valid || m_write_en || m_sense_en)
               obsHoldBad++;
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         rsp_ready = 1'b0;
         @(negedge clk);
         obsIdleOk = int'(m_req_ready && !m_rsp_valid && !m_precharge && !m_wl_valid &&
                          m_addr === v.addr);
      end
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      check({tag, ".acceptReady"}, obsAcceptReady, 1);
      check({tag, ".rspEdge"}, obsRspEdge, v.expRspEdge);
      check({tag, ".preFirst"}, obsPreFirst, v.expPreFirst);
      check({tag, ".preLast"}, obsPreLast, v.expPreLast);
      check({tag, ".preCount"}, obsPreCount, v.expPreLast - v.expPreFirst + 1);
      check({tag, ".wlFirst"}, obsWlFirst, v.expWlFirst);
      check({tag, ".wlLast"}, obsWlLast, v.expWlLast);
      check({tag, ".wlCount"}, obsWlCount, v.expWlLast - v.expWlFirst + 1);
      check({tag, ".weFirst"}, obsWeFirst, v.expWeFirst);
      check({tag, ".weCount"}, obsWeCount, v.expWeCount);
      check({tag, ".senseFirst"}, obsSenseFirst, v.expSense);
      check({tag, ".senseCount"}, obsSenseCount, (v.expSense > 0) ? 1 : 0);
      check({tag, ".rdata"}, 32'(obsRdata), 32'(v.expRdata));
      check({tag, ".rspWe"}, 32'(obsRspWe), 32'(v.we));
      check({tag, ".regHeld"}, obsRegBad, 0);
      check({tag, ".readyLow"}, obsReadyBad, 0);
      check({tag, ".respHold"}, obsHoldBad, 0);
      check({tag, ".idleAfter"}, obsIdleOk, 1);
   endtask

   initial begin
      vecs[0] = '{sel:0, we:0, addr:3'd5, wdata:8'h00, sa:8'hA5, bp:0, expRspEdge:5,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:5, expWeFirst:-1,
                  expWeCount:0, expSense:5, expRdata:8'hA5};
      vecs[1] = '{sel:0, we:1, addr:3'd3, wdata:8'h3C, sa:8'h11, bp:0, expRspEdge:4,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:4, expWeFirst:3,
                  expWeCount:2, expSense:-1, expRdata:8'hA5};
      vecs[2] = '{sel:0, we:0, addr:3'd1, wdata:8'h00, sa:8'h5A, bp:3, expRspEdge:5,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:5, expWeFirst:-1,
                  expWeCount:0, expSense:5, expRdata:8'h5A};
      vecs[3] = '{sel:0, we:1, addr:3'd6, wdata:8'hFF, sa:8'h00, bp:2, expRspEdge:4,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:4, expWeFirst:3,
                  expWeCount:2, expSense:-1, expRdata:8'h5A};
      vecs[4] = '{sel:0, we:0, addr:3'd0, wdata:8'h00, sa:8'h00, bp:1, expRspEdge:5,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:5, expWeFirst:-1,
                  expWeCount:0, expSense:5, expRdata:8'h00};
      vecs[5] = '{sel:0, we:0, addr:3'd7, wdata:8'h12, sa:8'h81, bp:0, expRspEdge:5,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:5, expWeFirst:-1,
                  expWeCount:0, expSense:5, expRdata:8'h81};
      vecs[6] = '{sel:1, we:0, addr:3'd2, wdata:8'h00, sa:8'hC3, bp:0, expRspEdge:17,
                  expPreFirst:1, expPreLast:1, expWlFirst:2, expWlLast:17, expWeFirst:-1,
                  expWeCount:0, expSense:17, expRdata:8'hC3};
      vecs[7] = '{sel:1, we:1, addr:3'd4, wdata:8'h81, sa:8'h66, bp:3, expRspEdge:16,
                  expPreFirst:1, expPreLast:1, expWlFirst:2, expWlLast:16, expWeFirst:2,
                  expWeCount:15, expSense:-1, expRdata:8'hC3};
      rstVec  = '{sel:0, we:0, addr:3'd2, wdata:8'h00, sa:8'h77, bp:0, expRspEdge:5,
                  expPreFirst:1, expPreLast:2, expWlFirst:3, expWlLast:5, expWeFirst:-1,
                  expWeCount:0, expSense:5, expRdata:8'h77};

      $display("[TB] reset values");
      @(negedge clk);
      check("rst.req_ready", 32'(m_req_ready), 1);
      check("rst.rsp_valid", 32'(m_rsp_valid), 0);
      check("rst.rsp_we", 32'(m_rsp_we), 0);
      check("rst.rsp_rdata", 32'(m_rsp_rdata), 0);
      check("rst.addr", 32'(m_addr), 0);
      check("rst.wdata", 32'(m_wdata), 0);
      check("rst.array", 32'({m_precharge, m_wl_valid, m_write_en, m_sense_en}), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] table vectors");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], $sformatf("v%0d", i));
      end

      $display("[TB] back-to-back reads with req_valid held");
      sel = 1'b0;
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0; req_wdata = 8'h00;
      sa_data = 8'h42; rsp_ready = 1'b1;
      @(negedge clk);
      a0 = edgeCnt;
      n = 0;
      while (!m_rsp_valid && n < 32) begin
         @(negedge clk);
         n++;
      end
      check("b2b.rsp0Edge", edgeCnt - a0, 5);
      check("b2b.rdata0", 32'(m_rsp_rdata), 32'h42);
      hs = edgeCnt + 1;
      req_addr = 3'd7; sa_data = 8'h99;
      @(negedge clk);
      check("b2b.readyAfterHs", 32'(m_req_ready), 1);
      check("b2b.addrBeforeAccept", 32'(m_addr), 0);
      check("b2b.rspDropped", 32'(m_rsp_valid), 0);
      @(negedge clk);
      a1 = hs + 1;
      check("b2b.accept1Ready", 32'(m_req_ready), 0);
      check("b2b.accept1Pre", 32'(m_precharge), 1);
      check("b2b.accept1Addr", 32'(m_addr), 7);
      req_valid = 1'b0;
      n = 0;
      while (!m_rsp_valid && n < 32) begin
         @(negedge clk);
         n++;
      end
      check("b2b.rsp1Edge", edgeCnt - a1, 5);
      check("b2b.rdata1", 32'(m_rsp_rdata), 32'h99);
      @(negedge clk);
      check("b2b.idle", 32'(m_req_ready), 1);
      rsp_ready = 1'b0;

      $display("[TB] reset during write access");
      req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 8'h3C;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid.wlBefore", 32'(m_wl_valid), 1);
      check("rstmid.weBefore", 32'(m_write_en), 1);
      #1;
      rst = 1'b1;
      #1;
      check("rstmid.wlAsync", 32'(m_wl_valid), 0);
      check("rstmid.weAsync", 32'(m_write_en), 0);
      check("rstmid.ready", 32'(m_req_ready), 1);
      check("rstmid.rspValid", 32'(m_rsp_valid), 0);
      rst = 1'b0;
      applyStimulus(rstVec);
      checkOutput(rstVec, "rstmid.read");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
